fetch_queue: RTL and testbench

- Fetch stage placed between the instruction memory (imemory) and the decode stage of the 5-stage RV32I pipeline.
- Generates fetch PCs and issues read requests to imemory, which has 1-cycle read latency.
- Buffers returned instructions with their PCs in a small FIFO and presents them to decode over a valid/ready handshake.
- Absorbs decode stalls without re-fetching, and flushes on branch/jump redirect so decode no longer needs NOP-injection muxing.

---
 rtl/fetch_queue_pkg.sv | 26 ++
 rtl/fetch_fifo.sv | 64 ++++++
 rtl/fetch_queue.sv | 109 ++++++++++
 tb/tb_fetch_queue.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared pipeline constants for the RV32I front end: the reset PC, the
// canonical NOP, and the major opcodes the fetch/decode boundary refers to.
package fetch_queue_pkg;

  localparam int          DATAW_DEF = 32;
  localparam logic [31:0] BASE_ADDR = 32'h0100_0000;
  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // RV32I major opcodes (instr[6:0])
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Instructions are word aligned; drop the two low address bits.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding {pc, instr} pairs between imemory and decode.
// flush empties the FIFO and wins over a push or pop in the same cycle.
// push into a full FIFO and pop from an empty FIFO are ignored.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  parameter int PTRW  = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [PTRW:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTRW-1:0]  rd_ptr;
  logic [PTRW-1:0]  wr_ptr;
  logic [PTRW:0]    count_q;
  logic             do_push;
  logic             do_pop;

  // Qualify requests against occupancy so the pointers can never overrun.
  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap freely.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTRW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTRW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PTRW+1)'(1);
        2'b01:   count_q <= count_q - (PTRW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: an entry is only visible once count covers it.
  always_ff @(posedge clock) begin
    if (do_push && !flush && !reset) mem[wr_ptr] <= push_data;
  end

  // Head entry and status flags.
  always_comb begin
    pop_data = mem[rd_ptr];
    full     = (count_q == (PTRW+1)'(DEPTH));
    empty    = (count_q == '0);
    count    = count_q;
  end

endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: generates fetch PCs, issues 1-cycle-latency reads to imemory,
// buffers {pc, instr} in fetch_fifo and presents them to decode.
//
// Handshake: out_valid/out_instr/out_pc describe the FIFO head; a transfer
// happens on a clock edge where out_valid && out_ready are both 1, and the
// head is then popped. out_valid does not depend on out_ready. A redirect
// overrides everything in its cycle, including a handshake.
//
// Issue uses a credit check (occupied entries + outstanding request < DEPTH),
// so every issued read has a guaranteed FIFO slot when it returns. A pop in
// the same cycle is deliberately not credited to keep the path short.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int               DATAW     = 32,
  parameter logic [DATAW-1:0] BASE_ADDR = fetch_queue_pkg::BASE_ADDR,
  parameter int               DEPTH     = 4,
  parameter int               PTRW      = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  output logic [DATAW-1:0] imem_addr,
  output logic             imem_enable,
  input  logic [DATAW-1:0] imem_rdata,
  input  logic             redirect_valid,
  input  logic [DATAW-1:0] redirect_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DATAW-1:0] out_instr,
  output logic [DATAW-1:0] out_pc,
  output logic [PTRW:0]    count
);

  logic [DATAW-1:0]   fetch_pc;
  logic               inflight;
  logic [DATAW-1:0]   inflight_pc;

  logic [PTRW+1:0]    used_slots;
  logic               credit_ok;
  logic               issue;

  logic               fifo_push;
  logic               fifo_pop;
  logic [2*DATAW-1:0] fifo_wdata;
  logic [2*DATAW-1:0] fifo_head;
  logic               fifo_full;
  logic               fifo_empty;
  logic [PTRW:0]      fifo_count;

  // Credit check and read issue; no issue during reset or a redirect cycle.
  always_comb begin
    used_slots  = {1'b0, fifo_count} + (PTRW+2)'(inflight);
    credit_ok   = (used_slots < (PTRW+2)'(DEPTH));
    issue       = !reset && !redirect_valid && credit_ok;
    imem_enable = issue;
    imem_addr   = fetch_pc;
  end

  // Response capture and decode-side pop; a redirect drops both.
  always_comb begin
    fifo_push  = inflight && !redirect_valid && !fifo_full;
    fifo_wdata = {inflight_pc, imem_rdata};
    fifo_pop   = !fifo_empty && out_ready && !redirect_valid;
  end

  fetch_fifo #(
    .WIDTH (2*DATAW),
    .DEPTH (DEPTH),
    .PTRW  (PTRW)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (fifo_push),
    .push_data (fifo_wdata),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // PC generation and outstanding-request tracking; redirect has priority.
  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc    <= BASE_ADDR;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect_valid) begin
      fetch_pc    <= {redirect_pc[DATAW-1:2], 2'b00};
      inflight    <= 1'b0;
    end else if (issue) begin
      fetch_pc    <= fetch_pc + DATAW'(4);
      inflight    <= 1'b1;
      inflight_pc <= fetch_pc;
    end else begin
      inflight    <= 1'b0;
    end
  end

  // Decode-facing outputs: head entry, or NOP/0 when the FIFO is empty.
  always_comb begin
    out_valid = !fifo_empty;
    out_instr = out_valid ? fifo_head[DATAW-1:0]       : DATAW'(NOP_INSTR);
    out_pc    = out_valid ? fifo_head[2*DATAW-1:DATAW] : '0;
    count     = fifo_count;
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios followed by random stimulus,
// every cycle compared against a transaction-level model of the fetch stage.
module tb_fetch_queue;

  localparam logic [31:0] BASE = 32'h0100_0000;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] KEY  = 32'hA5A5_A5A5;
  localparam int          QD   = 4;

  logic        clock;
  logic        reset;
  logic [31:0] imem_addr;
  logic        imem_enable;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [2:0]  count;

  int n_tests;
  int n_fail;

  fetch_queue dut (
    .clock          (clock),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_enable    (imem_enable),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .count          (count)
  );

  // ---------------- clock / reset block ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // imemory: one cycle read latency, contents = address ^ KEY
  always @(posedge clock) begin
    if (imem_enable) imem_rdata <= imem_addr ^ KEY;
  end

  // ---------------- reference model ----------------
  // exp_q holds {pc, instr} of every instruction decode has yet to receive.
  logic [63:0] exp_q[$];
  logic [31:0] m_fetch_pc;
  logic        m_pending;
  logic [31:0] m_pending_pc;

  task automatic model_reset();
    exp_q.delete();
    m_fetch_pc   = BASE;
    m_pending    = 1'b0;
    m_pending_pc = '0;
  endtask

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge: drive inputs, compare against the model, advance
  // the model across the next rising edge, and return at the next falling edge.
  task automatic cycle(input logic rst, input logic rv, input logic [31:0] rpc, input logic rdy);
    logic        e_en;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    reset          = rst;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    #1;
    e_en    = !rst && !rv && ((exp_q.size() + int'(m_pending)) < QD);
    e_valid = (exp_q.size() != 0);
    e_pc    = e_valid ? exp_q[0][63:32] : 32'h0;
    e_instr = e_valid ? exp_q[0][31:0]  : NOP;
    check("imem_enable", {31'b0, imem_enable}, {31'b0, e_en});
    if (e_en) check("imem_addr", imem_addr, m_fetch_pc);
    check("count",     {29'b0, count},     32'(exp_q.size()));
    check("out_valid", {31'b0, out_valid}, {31'b0, e_valid});
    check("out_pc",    out_pc,    e_pc);
    check("out_instr", out_instr, e_instr);
    // state after the coming edge
    if (rst) begin
      model_reset();
    end else if (rv) begin
      exp_q.delete();
      m_pending  = 1'b0;
      m_fetch_pc = {rpc[31:2], 2'b00};
    end else begin
      if (e_valid && rdy) void'(exp_q.pop_front());
      if (m_pending) exp_q.push_back({m_pending_pc, m_pending_pc ^ KEY});
      if (e_en) begin
        m_pending    = 1'b1;
        m_pending_pc = m_fetch_pc;
        m_fetch_pc   = m_fetch_pc + 32'd4;
      end else begin
        m_pending = 1'b0;
      end
    end
    @(negedge clock);
  endtask

  task automatic run(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0, rdy);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    @(negedge clock);
    model_reset();
    cycle(1'b1, 1'b0, 32'h0, 1'b1);            // reset state checked here

    // Stream with decode always ready: first out_valid two cycles after request
    run(2, 1'b1);
    check("first_valid", {31'b0, out_valid}, 32'd1);
    check("first_pc", out_pc, BASE);
    run(10, 1'b1);

    // Back-pressure from reset: fill, hold, then drain in order
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    run(10, 1'b0);
    check("sat_count", {29'b0, count}, 32'd4);
    check("sat_enable", {31'b0, imem_enable}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("drain_pc", out_pc, BASE + 32'(4 * i));
      cycle(1'b0, 1'b0, 32'h0, 1'b1);
    end
    run(4, 1'b1);

    // Redirect with three entries buffered and one request outstanding
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    run(4, 1'b0);
    check("pre_redir_count", {29'b0, count}, 32'd3);
    cycle(1'b0, 1'b1, 32'h0100_0103, 1'b0);
    check("redir_count", {29'b0, count}, 32'd0);
    check("redir_addr", imem_addr, 32'h0100_0100);
    run(2, 1'b1);
    check("redir_pc", out_pc, 32'h0100_0100);
    run(6, 1'b1);

    // Redirect coinciding with a pop and a response arrival
    cycle(1'b0, 1'b1, 32'h0200_0000, 1'b1);
    run(2, 1'b1);
    check("redir2_pc", out_pc, 32'h0200_0000);
    run(4, 1'b1);

    // PC wrap-around
    cycle(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1);
    run(3, 1'b1);
    check("wrap_pc_a", out_pc, 32'hFFFF_FFFC);
    run(1, 1'b1);
    check("wrap_pc_b", out_pc, 32'h0000_0000);
    run(4, 1'b1);

    // Reset while the FIFO is loaded and a request is outstanding
    cycle(1'b0, 1'b1, 32'h0300_0000, 1'b0);
    run(4, 1'b0);
    cycle(1'b1, 1'b0, 32'h0, 1'b0);
    check("rst_valid", {31'b0, out_valid}, 32'd0);
    check("rst_instr", out_instr, NOP);
    run(2, 1'b1);
    check("rst_restart_pc", out_pc, BASE);
    run(4, 1'b1);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      logic        r_rst;
      logic        r_rv;
      logic        r_rdy;
      logic [31:0] r_pc;
      r_rst = ($urandom_range(0, 99) == 0);
      r_rv  = ($urandom_range(0, 99) < 5);
      r_rdy = ($urandom_range(0, 99) < 65);
      r_pc  = $urandom();
      if ($urandom_range(0, 3) == 0) r_pc = 32'hFFFF_FFF0 | (r_pc & 32'hF);
      cycle(r_rst, r_rv, r_pc, r_rdy);
    end

    // drain what remains
    run(8, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
